// File: rtl/aes_arb_pkg.sv
// Shared definitions for the two-requester AES engine arbiter:
// FSM state encoding, default block/key width and owner encodings.
package aes_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam int unsigned BLK_W_DEFAULT = 128;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/aes_arb_rr.sv
// Two-way round-robin grant.
// Ports:
//   valid_a, valid_b : requesters with a pending job
//   owner            : last granted requester (OWNER_A / OWNER_B)
//   grant_a, grant_b : one-hot (or zero) grant; on a tie the requester
//                      that is not the current owner wins
module aes_arb_rr
  import aes_arb_pkg::*;
(
  input  logic valid_a,
  input  logic valid_b,
  input  logic owner,
  output logic grant_a,
  output logic grant_b
);

  always_comb begin
    grant_a = valid_a & (~valid_b | (owner == OWNER_B));
    grant_b = valid_b & (~valid_a | (owner == OWNER_A));
  end

endmodule

// File: rtl/aes_arbiter.sv
// Arbiter sharing one AES engine between requesters A and B.
// A granted job is latched into eng_block/eng_key, started with a one-cycle
// eng_start pulse, and the engine result is returned on rsp_data to the
// owning requester, held until that requester consumes it.
// Ports:
//   clk_clk, reset_reset_n         : clock, async active-low reset
//   req_{a,b}_valid/ready/block/key: job request handshakes and operands
//   rsp_{a,b}_valid/ready          : per-owner response handshakes
//   rsp_data, rsp_err              : shared result, watchdog abort flag
//   eng_start, eng_block, eng_key  : engine command
//   eng_done, eng_result           : engine completion
//   busy, owner                    : not-idle flag, last granted requester
// Optional feature: define AES_ARB_TIMEOUT_EN to enable the engine watchdog
// (abort after TIMEOUT_CYCLES cycles from eng_start, rsp_err=1, rsp_data=0).
module aes_arbiter
  import aes_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned BLK_W          = BLK_W_DEFAULT
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             req_a_valid,
  output logic             req_a_ready,
  input  logic [BLK_W-1:0] req_a_block,
  input  logic [BLK_W-1:0] req_a_key,
  input  logic             req_b_valid,
  output logic             req_b_ready,
  input  logic [BLK_W-1:0] req_b_block,
  input  logic [BLK_W-1:0] req_b_key,
  output logic             rsp_a_valid,
  input  logic             rsp_a_ready,
  output logic             rsp_b_valid,
  input  logic             rsp_b_ready,
  output logic [BLK_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic             eng_start,
  output logic [BLK_W-1:0] eng_block,
  output logic [BLK_W-1:0] eng_key,
  input  logic             eng_done,
  input  logic [BLK_W-1:0] eng_result,
  output logic             busy,
  output logic             owner
);

  if (TIMEOUT_CYCLES < 2) begin : g_tmo_check
    $error("aes_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t       state_q, state_d;
  logic             owner_q;
  logic [BLK_W-1:0] eng_block_q, eng_key_q, rsp_data_q;
  logic             grant_a, grant_b;
  logic             accept_a, accept_b;
  logic             rsp_hs;
  logic             done_in_wait;
  logic             timeout_hit;

  aes_arb_rr u_rr (
    .valid_a (req_a_valid),
    .valid_b (req_b_valid),
    .owner   (owner_q),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign req_a_ready  = (state_q == ST_IDLE) & grant_a;
  assign req_b_ready  = (state_q == ST_IDLE) & grant_b;
  assign accept_a     = req_a_valid & req_a_ready;
  assign accept_b     = req_b_valid & req_b_ready;
  assign rsp_a_valid  = (state_q == ST_RESP) & (owner_q == OWNER_A);
  assign rsp_b_valid  = (state_q == ST_RESP) & (owner_q == OWNER_B);
  assign rsp_hs       = (rsp_a_valid & rsp_a_ready) | (rsp_b_valid & rsp_b_ready);
  assign done_in_wait = (state_q == ST_WAIT) & eng_done;
  assign eng_start    = (state_q == ST_ISSUE);
  assign busy         = (state_q != ST_IDLE);
  assign owner        = owner_q;
  assign eng_block    = eng_block_q;
  assign eng_key      = eng_key_q;
  assign rsp_data     = rsp_data_q;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             rsp_err_q;

  // tmo_cnt_q holds the number of cycles elapsed since the eng_start cycle,
  // so the abort lands in RESP exactly TIMEOUT_CYCLES cycles after start.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tmo_cnt_q <= '0;
    end else if (accept_a | accept_b) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // A real completion in the same cycle wins over the watchdog.
  assign timeout_hit = (state_q == ST_WAIT) & ~eng_done &
                       (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rsp_err_q <= 1'b0;
    end else if (done_in_wait) begin
      rsp_err_q <= 1'b0;
    end else if (timeout_hit) begin
      rsp_err_q <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept_a | accept_b)        state_d = ST_ISSUE;
      ST_ISSUE:                                 state_d = ST_WAIT;
      ST_WAIT:  if (done_in_wait | timeout_hit) state_d = ST_RESP;
      ST_RESP:  if (rsp_hs)                     state_d = ST_IDLE;
      default:                                  state_d = ST_IDLE;
    endcase
  end

  // Operands are only loaded on accept, so they stay stable across the job.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      owner_q     <= OWNER_B;
      eng_block_q <= '0;
      eng_key_q   <= '0;
    end else if (accept_a) begin
      owner_q     <= OWNER_A;
      eng_block_q <= req_a_block;
      eng_key_q   <= req_a_key;
    end else if (accept_b) begin
      owner_q     <= OWNER_B;
      eng_block_q <= req_b_block;
      eng_key_q   <= req_b_key;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rsp_data_q <= '0;
    end else if (done_in_wait) begin
      rsp_data_q <= eng_result;
    end else if (timeout_hit) begin
      rsp_data_q <= '0;
    end
  end

endmodule

// File: tb/tb_aes_arbiter.sv
// Directed self-checking bench for aes_arbiter.
module tb_aes_arbiter;

  localparam int unsigned W = 128;

  logic         clk_clk = 1'b0;
  logic         reset_reset_n;
  logic         req_a_valid, req_a_ready, req_b_valid, req_b_ready;
  logic [W-1:0] req_a_block, req_a_key, req_b_block, req_b_key;
  logic         rsp_a_valid, rsp_a_ready, rsp_b_valid, rsp_b_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic         eng_start;
  logic [W-1:0] eng_block, eng_key;
  logic         eng_done;
  logic [W-1:0] eng_result;
  logic         busy, owner;

  int checks   = 0;
  int failures = 0;

  aes_arbiter #(.TIMEOUT_CYCLES(16), .BLK_W(W)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .req_a_valid   (req_a_valid),
    .req_a_ready   (req_a_ready),
    .req_a_block   (req_a_block),
    .req_a_key     (req_a_key),
    .req_b_valid   (req_b_valid),
    .req_b_ready   (req_b_ready),
    .req_b_block   (req_b_block),
    .req_b_key     (req_b_key),
    .rsp_a_valid   (rsp_a_valid),
    .rsp_a_ready   (rsp_a_ready),
    .rsp_b_valid   (rsp_b_valid),
    .rsp_b_ready   (rsp_b_ready),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .eng_start     (eng_start),
    .eng_block     (eng_block),
    .eng_key       (eng_key),
    .eng_done      (eng_done),
    .eng_result    (eng_result),
    .busy          (busy),
    .owner         (owner)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stand-in for the AES engine transform.
  function automatic logic [W-1:0] model(input logic [W-1:0] blk, input logic [W-1:0] key);
    return blk ^ {key[63:0], key[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
  endfunction

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic drive_req(input logic who, input logic [W-1:0] blk, input logic [W-1:0] key,
                           input logic v);
    if (who == 1'b0) begin
      req_a_valid = v; req_a_block = blk; req_a_key = key;
    end else begin
      req_b_valid = v; req_b_block = blk; req_b_key = key;
    end
  endtask

  task automatic set_rsp_ready(input logic who, input logic v);
    if (who == 1'b0) rsp_a_ready = v;
    else             rsp_b_ready = v;
  endtask

  // Entered near a negedge; returns at the negedge of the eng_start cycle.
  task automatic start_job(input logic who, input logic [W-1:0] blk, input logic [W-1:0] key,
                           input bit keep);
    int n = 0;
    drive_req(who, blk, key, 1'b1);
    #1;
    while (!(req_a_ready || req_b_ready) && n < 50) begin
      @(posedge clk_clk);
      @(negedge clk_clk);
      #1;
      n++;
    end
    check("grant", who ? req_b_ready : req_a_ready, 1'b1);
    step;
    if (!keep) drive_req(who, blk, key, 1'b0);
    @(negedge clk_clk);
    check("eng_start", eng_start, 1'b1);
    check("eng_block", eng_block, blk);
    check("eng_key", eng_key, key);
    check("owner", owner, who);
    check("busy", busy, 1'b1);
  endtask

  // Entered at the negedge of the eng_start cycle; engine completes lat
  // cycles after start; owner holds rsp_ready low for hold cycles.
  task automatic finish_job(input logic who, input logic [W-1:0] exp, input int lat,
                            input int hold, input bit chk_other);
    bit early = 0;
    for (int i = 1; i < lat; i++) begin
      step;
      @(negedge clk_clk);
      if (rsp_a_valid || rsp_b_valid) early = 1;
    end
    step;
    eng_done = 1'b1;
    eng_result = exp;
    @(negedge clk_clk);
    if (rsp_a_valid || rsp_b_valid) early = 1;
    step;
    eng_done = 1'b0;
    eng_result = ~exp;
    set_rsp_ready(who, hold == 0);
    @(negedge clk_clk);
    check("no_early_rsp", early, 1'b0);
    check("rsp_valid_owner", who ? rsp_b_valid : rsp_a_valid, 1'b1);
    check("rsp_valid_other", who ? rsp_a_valid : rsp_b_valid, 1'b0);
    check("rsp_data", rsp_data, exp);
    check("rsp_err", rsp_err, 1'b0);
    for (int h = 1; h < hold; h++) begin
      step;
      eng_done = (h == 2);
      @(negedge clk_clk);
      check("hold_valid", who ? rsp_b_valid : rsp_a_valid, 1'b1);
      check("hold_data", rsp_data, exp);
      if (chk_other) check("pending_blocked", who ? req_a_ready : req_b_ready, 1'b0);
    end
    if (hold > 0) begin
      step;
      eng_done = 1'b0;
      set_rsp_ready(who, 1'b1);
      @(negedge clk_clk);
      check("hs_valid", who ? rsp_b_valid : rsp_a_valid, 1'b1);
      check("hs_data", rsp_data, exp);
    end
    if (chk_other) check("no_accept_at_hs", who ? req_a_ready : req_b_ready, 1'b0);
    step;
    rsp_a_ready = 1'b0;
    rsp_b_ready = 1'b0;
    @(negedge clk_clk);
    check("rsp_cleared", rsp_a_valid | rsp_b_valid, 1'b0);
    if (chk_other) check("accept_after_hs", who ? req_a_ready : req_b_ready, 1'b1);
    else if (!(req_a_valid || req_b_valid)) check("idle_after_hs", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [W-1:0] blk_a, key_a, blk_b, key_b, prev;
    bit flag;

    reset_reset_n = 1'b0;
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    req_a_block = '0; req_a_key = '0; req_b_block = '0; req_b_key = '0;
    rsp_a_ready = 1'b0; rsp_b_ready = 1'b0;
    eng_done = 1'b0; eng_result = '0;

    repeat (3) @(posedge clk_clk);
    @(negedge clk_clk);
    check("rst_busy", busy, 1'b0);
    check("rst_owner", owner, 1'b1);
    check("rst_eng_start", eng_start, 1'b0);
    check("rst_rsp_valid", rsp_a_valid | rsp_b_valid, 1'b0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_eng_block", eng_block, '0);
    reset_reset_n = 1'b1;

    // Tie from reset: A first, then strict alternation.
    blk_a = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    key_a = 128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100;
    blk_b = 128'hfedc_ba98_7654_3210_ffee_ddcc_bbaa_9988;
    key_b = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    req_a_valid = 1'b1; req_a_block = blk_a; req_a_key = key_a;
    req_b_valid = 1'b1; req_b_block = blk_b; req_b_key = key_b;
    for (int j = 0; j < 8; j++) begin
      logic who;
      who = (j % 2 == 1);
      start_job(who, who ? blk_b : blk_a, who ? key_b : key_a, 1'b1);
      finish_job(who, who ? model(blk_b, key_b) : model(blk_a, key_a), 2, 0, 1'b0);
    end
    req_a_valid = 1'b0;
    req_b_valid = 1'b0;

    // Single A job, engine 10 cycles after start.
    blk_a = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
    key_a = 128'h0001_0203_0405_0607_0809_0a0b_0c0d_0e0f;
    start_job(1'b0, blk_a, key_a, 1'b0);
    finish_job(1'b0, model(blk_a, key_a), 10, 0, 1'b0);

    // Spurious eng_done while idle.
    prev = model(blk_a, key_a);
    step;
    eng_done = 1'b1;
    eng_result = ~prev;
    @(negedge clk_clk);
    step;
    eng_done = 1'b0;
    @(negedge clk_clk);
    check("idle_done_busy", busy, 1'b0);
    check("idle_done_data", rsp_data, prev);
    check("idle_done_valid", rsp_a_valid | rsp_b_valid, 1'b0);

    // A response stalled 5 cycles with B pending.
    blk_a = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    key_a = 128'hcafe_f00d_aaaa_bbbb_cccc_dddd_eeee_ffff;
    blk_b = 128'h1357_9bdf_2468_ace0_1357_9bdf_2468_ace0;
    key_b = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
    start_job(1'b0, blk_a, key_a, 1'b0);
    drive_req(1'b1, blk_b, key_b, 1'b1);
    finish_job(1'b0, model(blk_a, key_a), 4, 5, 1'b1);
    start_job(1'b1, blk_b, key_b, 1'b0);
    finish_job(1'b1, model(blk_b, key_b), 3, 0, 1'b0);

    // Silent engine.
    blk_a = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    key_a = 128'h0123_0123_0123_0123_0123_0123_0123_0123;
    start_job(1'b0, blk_a, key_a, 1'b0);
    flag = 0;
`ifdef AES_ARB_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      step;
      @(negedge clk_clk);
      if (rsp_a_valid || rsp_b_valid) flag = 1;
    end
    check("tmo_not_early", flag, 1'b0);
    step;
    @(negedge clk_clk);
    check("tmo_valid", rsp_a_valid, 1'b1);
    check("tmo_err", rsp_err, 1'b1);
    check("tmo_data", rsp_data, '0);
    step;
    rsp_a_ready = 1'b1;
    @(negedge clk_clk);
    step;
    rsp_a_ready = 1'b0;
    @(negedge clk_clk);
    check("tmo_idle", busy, 1'b0);
    start_job(1'b0, blk_a, key_a, 1'b0);
    repeat (3) step;
    @(negedge clk_clk);
`else
    for (int k = 0; k < 40; k++) begin
      step;
      @(negedge clk_clk);
      if (rsp_a_valid || rsp_b_valid || !busy) flag = 1;
    end
    check("silent_busy", busy, 1'b1);
    check("silent_no_rsp", flag, 1'b0);
`endif

    // Reset while waiting on the engine.
    step;
    reset_reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_eng_start", eng_start, 1'b0);
    check("mid_rst_eng_block", eng_block, '0);
    check("mid_rst_eng_key", eng_key, '0);
    check("mid_rst_rsp_data", rsp_data, '0);
    check("mid_rst_rsp_err", rsp_err, 1'b0);
    check("mid_rst_owner", owner, 1'b1);
    check("mid_rst_rsp_valid", rsp_a_valid | rsp_b_valid, 1'b0);
    check("mid_rst_ready", req_a_ready | req_b_ready, 1'b0);
    repeat (2) step;
    reset_reset_n = 1'b1;
    flag = 0;
    repeat (3) step;
    eng_done = 1'b1;
    eng_result = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
    @(negedge clk_clk);
    for (int k = 0; k < 4; k++) begin
      step;
      eng_done = 1'b0;
      @(negedge clk_clk);
      if (rsp_a_valid || rsp_b_valid || busy) flag = 1;
    end
    check("post_rst_quiet", flag, 1'b0);
    check("post_rst_data", rsp_data, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_arbiter.md
AES_ARBITER -- requirements
Module: aes_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, engine watchdog limit in cycles (used only with AES_ARB_TIMEOUT_EN).
REQ-002 SHALL have parameter BLK_W, default 128, AES block and key width in bits.
REQ-003 clk_clk  in  1  sole clock, all state on rising edge.
REQ-004 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-005 req_a_valid / req_b_valid  in  1  requester A/B has a job pending.
REQ-006 req_a_ready / req_b_ready  out  1  job accepted this cycle.
REQ-007 req_a_block, req_a_key, req_b_block, req_b_key  in  BLK_W  plaintext and key per requester.
REQ-008 rsp_a_valid / rsp_b_valid  out  1  result available to owner.
REQ-009 rsp_a_ready / rsp_b_ready  in  1  owner consumes result.
REQ-010 rsp_data  out  BLK_W  ciphertext, shared by both response ports.
REQ-011 rsp_err  out  1  job aborted by watchdog.
REQ-012 eng_start  out  1  one-cycle start pulse to AES engine.
REQ-013 eng_block, eng_key  out  BLK_W  operands, held stable from eng_start until eng_done.
REQ-014 eng_done  in  1  engine completion pulse; eng_result  in  BLK_W  valid with eng_done.
REQ-015 busy  out  1  state not IDLE; owner  out  1  0=A, 1=B, last granted requester.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; reset state IDLE.
REQ-017 IDLE: if exactly one req_x_valid, grant it; if both, grant the requester not equal to owner (round-robin).
REQ-018 req_x_ready SHALL be combinational, high only in IDLE for the granted requester; accept = valid & ready.
REQ-019 On accept: latch block/key into eng_block/eng_key, update owner, go ISSUE.
REQ-020 ISSUE: eng_start high exactly one cycle, go WAIT.
REQ-021 WAIT: on eng_done latch eng_result into rsp_data, rsp_err=0, go RESP; eng_done outside WAIT SHALL be ignored.
REQ-022 RESP: rsp_x_valid high for owner only, held until rsp_x_ready; on handshake go IDLE.
REQ-023 Latency: accept at cycle T, eng_start at T+1, eng_done at D gives rsp_x_valid at D+1.
REQ-024 A new request SHALL NOT be accepted in the cycle of the response handshake (earliest accept one cycle later).
REQ-025 A request valid deasserting before acceptance SHALL be dropped without side effect.
REQ-026 rsp_data and rsp_err SHALL be held stable while rsp_x_valid is high.

Reset
REQ-027 Reset asserted: state IDLE, owner=1 (so A wins first tie), all ready/valid/eng_start=0, eng_block/eng_key/rsp_data=0, rsp_err=0, busy=0.
REQ-028 Reset mid-job SHALL abort immediately; a later eng_done SHALL be ignored.

Configuration
REQ-029 Macro AES_ARB_TIMEOUT_EN defined: counter cleared at ISSUE, incremented in WAIT; on reaching TIMEOUT_CYCLES without eng_done go RESP with rsp_err=1, rsp_data=0.
REQ-030 Macro undefined: no counter; WAIT waits indefinitely; rsp_err tied 0.
REQ-031 eng_done in the same cycle the timeout would fire SHALL take priority (normal result).

Structure
REQ-032 Shared package aes_arb_pkg SHALL hold the state enum, BLK_W default, and owner encodings OWNER_A/OWNER_B.
REQ-033 Sub-module aes_arb_rr (2-way round-robin grant from valids and owner) is natural; FSM and datapath stay in aes_arbiter.

Verification
REQ-034 Single A job: req_a_valid with block 0x00112233..., engine model done 10 cycles after start -> eng_start at T+1, rsp_a_valid at T+12, rsp_data = model output, rsp_b_valid never high.
REQ-035 Both valid after reset -> A granted first, owner=0; B granted on the next job, owner=1; alternation continues for 8 jobs (ABABABAB).
REQ-036 rsp_a_ready held low 5 cycles -> rsp_a_valid and rsp_data stable 5 cycles, pending B not accepted until one cycle after handshake.
REQ-037 Spurious eng_done in IDLE and RESP -> no state change, rsp_data unchanged.
REQ-038 AES_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, engine silent -> rsp_err=1, rsp_data=0 exactly 16 cycles after start; without the macro busy stays high.
REQ-039 reset_reset_n low during WAIT, engine done 3 cycles after release -> all outputs at reset values, no response issued.
